// File: rtl/operand_fetch_if.sv
// Bus between the operand-fetch stage and its neighbours: IF/ID input, register-file
// read port, EX/MEM/WB bypass sources, redirect flush, and the ID/EX output register.
interface operand_fetch_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
);
  logic               in_valid;
  logic [31:0]        in_instr;
  logic [XLEN-1:0]    in_pc;
  logic               in_ready;
  logic [RADDR_W-1:0] rf_raddr0;
  logic [RADDR_W-1:0] rf_raddr1;
  logic [XLEN-1:0]    rf_rdata0;
  logic [XLEN-1:0]    rf_rdata1;
  logic [XLEN-1:0]    ex_fwd_data;
  logic               mem_wen;
  logic [RADDR_W-1:0] mem_waddr;
  logic [XLEN-1:0]    mem_data;
  logic               wb_wen;
  logic [RADDR_W-1:0] wb_waddr;
  logic [XLEN-1:0]    wb_data;
  logic               flush;
  logic               out_ready;
  logic               out_valid;
  logic [XLEN-1:0]    out_pc;
  logic [31:0]        out_instr;
  logic [XLEN-1:0]    out_op_a;
  logic [XLEN-1:0]    out_op_b;
  logic [RADDR_W-1:0] out_dest;
  logic               out_wen;
  logic               out_is_load;

  modport slave (
    input  in_valid, in_instr, in_pc, rf_rdata0, rf_rdata1, ex_fwd_data,
           mem_wen, mem_waddr, mem_data, wb_wen, wb_waddr, wb_data, flush, out_ready,
    output in_ready, rf_raddr0, rf_raddr1, out_valid, out_pc, out_instr,
           out_op_a, out_op_b, out_dest, out_wen, out_is_load
  );

  modport master (
    output in_valid, in_instr, in_pc, rf_rdata0, rf_rdata1, ex_fwd_data,
           mem_wen, mem_waddr, mem_data, wb_wen, wb_waddr, wb_data, flush, out_ready,
    input  in_ready, rf_raddr0, rf_raddr1, out_valid, out_pc, out_instr,
           out_op_a, out_op_b, out_dest, out_wen, out_is_load
  );
endinterface

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: field decode, bypass operand select, load-use
// interlock and the ID/EX register with valid/ready handshake and flush.
module operand_fetch_opsel #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic [RADDR_W-1:0] i_src,
  input  logic               i_ex_en,
  input  logic [RADDR_W-1:0] i_ex_dest,
  input  logic [XLEN-1:0]    i_ex_data,
  input  logic               i_mem_wen,
  input  logic [RADDR_W-1:0] i_mem_waddr,
  input  logic [XLEN-1:0]    i_mem_data,
  input  logic               i_wb_wen,
  input  logic [RADDR_W-1:0] i_wb_waddr,
  input  logic [XLEN-1:0]    i_wb_data,
  input  logic [XLEN-1:0]    i_rf_data,
  output logic [XLEN-1:0]    o_data
);
  // Youngest producer wins; WB beats the RF because the RF returns pre-write data.
  always_comb begin
    o_data = i_rf_data;
    if (i_src == '0)                                o_data = '0;
    else if (i_ex_en && i_ex_dest == i_src)         o_data = i_ex_data;
    else if (i_mem_wen && i_mem_waddr == i_src)     o_data = i_mem_data;
    else if (i_wb_wen && i_wb_waddr == i_src)       o_data = i_wb_data;
  end
endmodule

module operand_fetch #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input logic           clk,
  input logic           rst_n,
  operand_fetch_if.slave bus
);
  logic [5:0]                    w_op, w_funct;
  logic [RADDR_W-1:0]            w_rs, w_rt, w_rd, w_dest;
  logic                          w_wen, w_is_load, w_use_rs, w_use_rt;
  logic [1:0][RADDR_W-1:0]       w_src;
  logic [1:0][XLEN-1:0]          w_rdata, w_opnd;
  logic [1:0]                    w_use, w_ld_hit;
  logic                          w_ex_en, w_load_use, w_advance, w_take;

  logic                          r_valid, r_wen, r_is_load;
  logic [XLEN-1:0]               r_pc, r_op_a, r_op_b;
  logic [31:0]                   r_instr;
  logic [RADDR_W-1:0]            r_dest;

  assign w_op    = bus.in_instr[31:26];
  assign w_rs    = bus.in_instr[25:21];
  assign w_rt    = bus.in_instr[20:16];
  assign w_rd    = bus.in_instr[15:11];
  assign w_funct = bus.in_instr[5:0];

  assign bus.rf_raddr0 = w_rs;
  assign bus.rf_raddr1 = w_rt;

  always_comb begin
    w_dest = '0;
    w_wen  = 1'b0;
    case (w_op)
      6'h00: begin
        w_dest = w_rd;
        w_wen  = (w_funct != 6'h08);
      end
      6'h23, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F: begin
        w_dest = w_rt;
        w_wen  = 1'b1;
      end
      6'h03: begin
        w_dest = RADDR_W'(31);
        w_wen  = 1'b1;
      end
      default: ;
    endcase
    // $0 is hardwired, so a write to it is no write at all
    if (w_dest == '0) w_wen = 1'b0;
  end

  assign w_is_load = (w_op == 6'h23);
  assign w_use_rt  = (w_op == 6'h00) | (w_op == 6'h2B) | (w_op == 6'h04) | (w_op == 6'h05);
  assign w_use_rs  = !((w_op == 6'h02) | (w_op == 6'h03) | (w_op == 6'h0F));

  assign w_src   = {w_rt, w_rs};
  assign w_rdata = {bus.rf_rdata1, bus.rf_rdata0};
  assign w_use   = {w_use_rt, w_use_rs};
  // A load in EX has no data yet; it is only usable from MEM onwards.
  assign w_ex_en = r_valid & r_wen & ~r_is_load;

  generate
    for (genvar g = 0; g < 2; g++) begin : g_src
      operand_fetch_opsel #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_sel (
        .i_src       (w_src[g]),
        .i_ex_en     (w_ex_en),
        .i_ex_dest   (r_dest),
        .i_ex_data   (bus.ex_fwd_data),
        .i_mem_wen   (bus.mem_wen),
        .i_mem_waddr (bus.mem_waddr),
        .i_mem_data  (bus.mem_data),
        .i_wb_wen    (bus.wb_wen),
        .i_wb_waddr  (bus.wb_waddr),
        .i_wb_data   (bus.wb_data),
        .i_rf_data   (w_rdata[g]),
        .o_data      (w_opnd[g])
      );
      assign w_ld_hit[g] = w_use[g] & (w_src[g] == r_dest);
    end
  endgenerate

  assign w_load_use   = bus.in_valid & r_valid & r_is_load & (r_dest != '0) & (|w_ld_hit);
  assign w_advance    = bus.out_ready | ~r_valid;
  assign w_take       = bus.in_valid & ~w_load_use;
  assign bus.in_ready = bus.flush | (w_advance & ~w_load_use);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_instr   <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_dest    <= '0;
      r_wen     <= 1'b0;
      r_is_load <= 1'b0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_advance) begin
      if (w_take) begin
        r_valid   <= 1'b1;
        r_pc      <= bus.in_pc;
        r_instr   <= bus.in_instr;
        r_op_a    <= w_opnd[0];
        r_op_b    <= w_opnd[1];
        r_dest    <= w_dest;
        r_wen     <= w_wen;
        r_is_load <= w_is_load;
      end else begin
        // bubble: payload is stale but must not look like a producer
        r_valid   <= 1'b0;
        r_wen     <= 1'b0;
        r_is_load <= 1'b0;
      end
    end
  end

  assign bus.out_valid   = r_valid;
  assign bus.out_pc      = r_pc;
  assign bus.out_instr   = r_instr;
  assign bus.out_op_a    = r_op_a;
  assign bus.out_op_b    = r_op_b;
  assign bus.out_dest    = r_dest;
  assign bus.out_wen     = r_wen;
  assign bus.out_is_load = r_is_load;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: reference slot model checked every cycle plus
// hand-computed literal expectations for the key scenarios.
module tb_operand_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  operand_fetch_if bus ();
  operand_fetch u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [4:0] dest;
    logic       wen, ld, use_rs, use_rt;
  } dec_t;

  // reference ID/EX slot
  logic        m_valid, m_wen, m_ld;
  logic [31:0] m_pc, m_instr, m_a, m_b;
  logic [4:0]  m_dest;

  function automatic dec_t dec(input logic [31:0] i);
    dec_t d;
    logic [5:0] op;
    op = i[31:26];
    d.dest = 5'd0;
    d.wen  = 1'b0;
    if (op == 6'h00) begin
      d.dest = i[15:11];
      d.wen  = (i[5:0] != 6'h08);
    end else if (op inside {6'h23, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F}) begin
      d.dest = i[20:16];
      d.wen  = 1'b1;
    end else if (op == 6'h03) begin
      d.dest = 5'd31;
      d.wen  = 1'b1;
    end
    if (d.dest == 5'd0) d.wen = 1'b0;
    d.ld     = (op == 6'h23);
    d.use_rt = op inside {6'h00, 6'h2B, 6'h04, 6'h05};
    d.use_rs = !(op inside {6'h02, 6'h03, 6'h0F});
    return d;
  endfunction

  function automatic logic [31:0] pick(input logic [4:0] s, input logic [31:0] rf);
    if (s == 5'd0) return 32'd0;
    if (m_valid && m_wen && !m_ld && m_dest == s) return bus.ex_fwd_data;
    if (bus.mem_wen && bus.mem_waddr == s) return bus.mem_data;
    if (bus.wb_wen && bus.wb_waddr == s) return bus.wb_data;
    return rf;
  endfunction

  function automatic logic exp_lu();
    dec_t d;
    d = dec(bus.in_instr);
    return bus.in_valid && m_valid && m_ld && m_dest != 5'd0 &&
           ((d.use_rs && bus.in_instr[25:21] == m_dest) ||
            (d.use_rt && bus.in_instr[20:16] == m_dest));
  endfunction

  function automatic logic exp_ready();
    return bus.flush || ((bus.out_ready || !m_valid) && !exp_lu());
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_wen <= 1'b0; m_ld <= 1'b0; m_dest <= '0;
      m_pc <= '0; m_instr <= '0; m_a <= '0; m_b <= '0;
    end else if (bus.flush) begin
      m_valid <= 1'b0;
    end else if (bus.out_ready || !m_valid) begin
      if (bus.in_valid && !exp_lu()) begin
        m_valid <= 1'b1;
        m_pc    <= bus.in_pc;
        m_instr <= bus.in_instr;
        m_a     <= pick(bus.in_instr[25:21], bus.rf_rdata0);
        m_b     <= pick(bus.in_instr[20:16], bus.rf_rdata1);
        m_dest  <= dec(bus.in_instr).dest;
        m_wen   <= dec(bus.in_instr).wen;
        m_ld    <= dec(bus.in_instr).ld;
      end else begin
        m_valid <= 1'b0; m_wen <= 1'b0; m_ld <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // compare process: model vs DUT on every falling edge
  always @(negedge clk) begin
    check("m_in_ready", 32'(bus.in_ready), 32'(exp_ready()));
    check("m_raddr0", 32'(bus.rf_raddr0), 32'(bus.in_instr[25:21]));
    check("m_raddr1", 32'(bus.rf_raddr1), 32'(bus.in_instr[20:16]));
    check("m_out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("m_out_wen", 32'(bus.out_wen), 32'(m_wen));
    check("m_out_is_load", 32'(bus.out_is_load), 32'(m_ld));
    if (m_valid) begin
      check("m_out_pc", bus.out_pc, m_pc);
      check("m_out_instr", bus.out_instr, m_instr);
      check("m_out_op_a", bus.out_op_a, m_a);
      check("m_out_op_b", bus.out_op_b, m_b);
      check("m_out_dest", 32'(bus.out_dest), 32'(m_dest));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
  endtask

  initial begin
    bus.in_valid = 0; bus.in_instr = 0; bus.in_pc = 0;
    bus.rf_rdata0 = 0; bus.rf_rdata1 = 0; bus.ex_fwd_data = 0;
    bus.mem_wen = 0; bus.mem_waddr = 0; bus.mem_data = 0;
    bus.wb_wen = 0; bus.wb_waddr = 0; bus.wb_data = 0;
    bus.flush = 0; bus.out_ready = 1;
    repeat (2) cyc();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_wen", 32'(bus.out_wen), 32'd0);
    check("rst_out_pc", bus.out_pc, 32'd0);
    rst_n = 1'b1;
    cyc();

    // addi $1,$0,5
    issue(32'h20010005, 32'h100);
    #1;
    check("addi_raddr0", 32'(bus.rf_raddr0), 32'd0);
    check("addi_raddr1", 32'(bus.rf_raddr1), 32'd1);
    cyc();
    check("addi_valid", 32'(bus.out_valid), 32'd1);
    check("addi_dest", 32'(bus.out_dest), 32'd1);
    check("addi_wen", 32'(bus.out_wen), 32'd1);
    check("addi_op_a", bus.out_op_a, 32'd0);

    // add $3,$1,$2 with addi $1 in EX
    issue(32'h00221820, 32'h104);
    bus.ex_fwd_data = 32'd5; bus.rf_rdata0 = 32'd0; bus.rf_rdata1 = 32'h22;
    #1;
    check("dep_in_ready", 32'(bus.in_ready), 32'd1);
    cyc();
    check("dep_op_a", bus.out_op_a, 32'd5);
    check("dep_op_b", bus.out_op_b, 32'h22);
    check("dep_dest", 32'(bus.out_dest), 32'd3);

    // lw $4,0($0) then add $5,$4,$4
    bus.ex_fwd_data = 0; bus.rf_rdata1 = 0;
    issue(32'h8C040000, 32'h108);
    cyc();
    issue(32'h00842820, 32'h10C);
    #1;
    check("lu_in_ready", 32'(bus.in_ready), 32'd0);
    cyc();
    check("lu_bubble", 32'(bus.out_valid), 32'd0);
    bus.mem_wen = 1; bus.mem_waddr = 5'd4; bus.mem_data = 32'hDEADBEEF;
    #1;
    check("lu_in_ready2", 32'(bus.in_ready), 32'd1);
    cyc();
    check("lu_valid", 32'(bus.out_valid), 32'd1);
    check("lu_op_a", bus.out_op_a, 32'hDEADBEEF);
    check("lu_op_b", bus.out_op_b, 32'hDEADBEEF);
    bus.mem_wen = 0;

    // WB bypass on rt=7: add $8,$0,$7
    issue(32'h00074020, 32'h110);
    bus.wb_wen = 1; bus.wb_waddr = 5'd7; bus.wb_data = 32'h1234; bus.rf_rdata1 = 0;
    cyc();
    check("wb_op_b", bus.out_op_b, 32'h1234);
    bus.wb_waddr = 5'd0;
    issue(32'h00074020, 32'h114);
    cyc();
    check("wb0_op_b", bus.out_op_b, 32'd0);
    bus.wb_wen = 0;

    // priority on $9
    issue(32'h20090007, 32'h118);
    cyc();
    issue(32'h01205020, 32'h11C);
    bus.ex_fwd_data = 32'd1;
    bus.mem_wen = 1; bus.mem_waddr = 5'd9; bus.mem_data = 32'd2;
    bus.wb_wen = 1; bus.wb_waddr = 5'd9; bus.wb_data = 32'd3;
    cyc();
    check("prio_ex", bus.out_op_a, 32'd1);
    issue(32'h01205020, 32'h120);
    cyc();
    check("prio_mem", bus.out_op_a, 32'd2);
    bus.mem_wen = 0; bus.wb_wen = 0; bus.ex_fwd_data = 0;

    // downstream stall, then flush
    bus.out_ready = 0;
    issue(32'h8C020000, 32'h200);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      cyc();
      check("stall_hold_pc", bus.out_pc, 32'h120);
    end
    bus.flush = 1;
    #1;
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    cyc();
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    bus.flush = 0; bus.out_ready = 1;

    // lw $2 then sw $2,0($1): rt-only load-use
    issue(32'h8C020000, 32'h204);
    cyc();
    issue(32'hAC220000, 32'h208);
    #1;
    check("sw_lu_in_ready", 32'(bus.in_ready), 32'd0);
    cyc();
    bus.mem_wen = 1; bus.mem_waddr = 5'd2; bus.mem_data = 32'h55;
    cyc();
    check("sw_op_b", bus.out_op_b, 32'h55);
    check("sw_wen", 32'(bus.out_wen), 32'd0);
    bus.mem_wen = 0;
    issue(32'h0C000010, 32'h20C);   // jal
    cyc();
    check("jal_dest", 32'(bus.out_dest), 32'd31);
    check("jal_wen", 32'(bus.out_wen), 32'd1);
    issue(32'h03E00008, 32'h210);   // jr $31
    bus.ex_fwd_data = 32'h214;
    cyc();
    check("jr_wen", 32'(bus.out_wen), 32'd0);
    check("jr_op_a", bus.out_op_a, 32'h214);
    issue(32'h20200003, 32'h214);   // addi $0,$1,3
    cyc();
    check("dest0_wen", 32'(bus.out_wen), 32'd0);
    bus.in_valid = 0;
    cyc();
    check("idle_bubble", 32'(bus.out_valid), 32'd0);

    // reset mid-operation
    issue(32'h20010005, 32'h300);
    cyc();
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 0;
    cyc();
    rst_n = 1'b1;
    cyc();
    check("postrst_valid", 32'(bus.out_valid), 32'd0);
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
